// File: rtl/card_selection_encoder.sv
// ---------------------------------------------------------------------------
// card_selection_encoder
//
// Collects three card picks from the switch index and pick button and packs
// them into a 12-bit selection word for the selection-clearing datapath.
// Invalid picks (index 0, index above MAX_INDEX) and duplicate picks are
// rejected with a one-cycle error pulse. A complete word is held stable with
// a request flag until the clearer reports completion. The block then waits
// for the completion flag to drop and re-arms for the next round.
//
// Ports
//   clk         in   1   system clock
//   reset       in   1   asynchronous, active-high reset
//   key_idx     in   4   card index on switches, sampled on the accept cycle
//   key_press   in   1   raw pick button level, asynchronous to clk
//   abort       in   1   discards a partial selection while collecting
//   clear_done  in   1   clearer handshake, high when all cards are cleared
//   data_out    out  12  [3:0]=1st pick, [7:4]=2nd, [11:8]=3rd, empty = 0
//   sel_count   out  2   number of stored picks, 0..3
//   sel_valid   out  1   selection word complete and stable
//   busy        out  1   waiting on the clearer, picks ignored
//   err_pulse   out  1   one-cycle pulse on a rejected pick
// ---------------------------------------------------------------------------
module card_selection_encoder #(
    parameter int MAX_INDEX    = 9,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_idx,
    input  logic        key_press,
    input  logic        abort,
    input  logic        clear_done,
    output logic [11:0] data_out,
    output logic [1:0]  sel_count,
    output logic        sel_valid,
    output logic        busy,
    output logic        err_pulse
);

    localparam int            CW      = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] DB_FULL = CW'(DEBOUNCE_CYC);
    localparam logic [3:0]    IDX_MAX = 4'(MAX_INDEX);

    typedef enum logic [1:0] {
        S_COLLECT = 2'b00,
        S_REQ     = 2'b01,
        S_ACK     = 2'b10
    } state_t;

    state_t        state_r;
    logic          sync1_r;
    logic          sync2_r;
    logic          press_latched_r;
    logic [CW-1:0] hi_cnt_r;
    logic [CW-1:0] lo_cnt_r;

    logic          accept_s;
    logic          release_s;
    logic          reject_s;

    // Press/release recognition and pick legality.
    always_comb begin
        accept_s  = 1'b0;
        release_s = 1'b0;
        reject_s  = 1'b0;

        // The counters hold the number of earlier consecutive cycles, so the
        // current cycle completes the run when a counter reads DEBOUNCE_CYC-1.
        if (sync2_r && (hi_cnt_r == DB_LAST) && !press_latched_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end

        if (!sync2_r && (lo_cnt_r == DB_LAST) && press_latched_r) begin
            release_s = 1'b1;
        end else begin
            release_s = 1'b0;
        end

        // Empty slots read as 0 and index 0 is already illegal, so comparing
        // against every slot only ever matches a stored pick.
        if ((key_idx == 4'd0) || (key_idx > IDX_MAX) ||
            (key_idx == data_out[3:0]) || (key_idx == data_out[7:4]) ||
            (key_idx == data_out[11:8])) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
    end

    // Button synchroniser, high/low run counters and the one-accept-per-press latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r         <= 1'b0;
            sync2_r         <= 1'b0;
            hi_cnt_r        <= '0;
            lo_cnt_r        <= '0;
            press_latched_r <= 1'b0;
        end else begin
            sync1_r <= key_press;
            sync2_r <= sync1_r;

            // Counters saturate so a long hold or idle never wraps into a new event.
            if (sync2_r) begin
                lo_cnt_r <= '0;
                if (hi_cnt_r < DB_FULL) begin
                    hi_cnt_r <= hi_cnt_r + 1'b1;
                end else begin
                    hi_cnt_r <= hi_cnt_r;
                end
            end else begin
                hi_cnt_r <= '0;
                if (lo_cnt_r < DB_FULL) begin
                    lo_cnt_r <= lo_cnt_r + 1'b1;
                end else begin
                    lo_cnt_r <= lo_cnt_r;
                end
            end

            if (accept_s) begin
                press_latched_r <= 1'b1;
            end else if (release_s) begin
                press_latched_r <= 1'b0;
            end else begin
                press_latched_r <= press_latched_r;
            end
        end
    end

    // Selection FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_COLLECT;
            data_out  <= 12'd0;
            sel_count <= 2'd0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state_r)
                S_COLLECT: begin
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                    // Abort has priority; a coinciding pick is dropped silently.
                    if (abort) begin
                        data_out  <= 12'd0;
                        sel_count <= 2'd0;
                    end else if (accept_s) begin
                        if (reject_s) begin
                            err_pulse <= 1'b1;
                        end else begin
                            case (sel_count)
                                2'd0: begin
                                    data_out[3:0] <= key_idx;
                                    sel_count     <= 2'd1;
                                end
                                2'd1: begin
                                    data_out[7:4] <= key_idx;
                                    sel_count     <= 2'd2;
                                end
                                2'd2: begin
                                    data_out[11:8] <= key_idx;
                                    sel_count      <= 2'd3;
                                    state_r        <= S_REQ;
                                    sel_valid      <= 1'b1;
                                    busy           <= 1'b1;
                                end
                                default: begin
                                    // A full count cannot occur while collecting; start over.
                                    data_out  <= 12'd0;
                                    sel_count <= 2'd0;
                                end
                            endcase
                        end
                    end else begin
                        sel_count <= sel_count;
                    end
                end

                S_REQ: begin
                    busy <= 1'b1;
                    if (accept_s) begin
                        err_pulse <= 1'b1;
                    end else begin
                        err_pulse <= 1'b0;
                    end
                    if (clear_done) begin
                        state_r   <= S_ACK;
                        sel_valid <= 1'b0;
                    end else begin
                        sel_valid <= 1'b1;
                    end
                end

                S_ACK: begin
                    sel_valid <= 1'b0;
                    // Wait for the clearer to drop its flag so one round is never counted twice.
                    if (!clear_done) begin
                        state_r   <= S_COLLECT;
                        data_out  <= 12'd0;
                        sel_count <= 2'd0;
                        busy      <= 1'b0;
                    end else begin
                        busy <= 1'b1;
                    end
                end

                default: begin
                    state_r   <= S_COLLECT;
                    data_out  <= 12'd0;
                    sel_count <= 2'd0;
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_card_selection_encoder.sv
// ---------------------------------------------------------------------------
// Testbench for card_selection_encoder: directed vector table, timed corner
// sequences, and randomized picks/aborts/handshakes against a pick-list model.
// ---------------------------------------------------------------------------
module tb_card_selection_encoder;

    localparam int D    = 4;
    localparam int MAXI = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key_idx;
    logic        key_press;
    logic        abort;
    logic        clear_done;
    logic [11:0] data_out;
    logic [1:0]  sel_count;
    logic        sel_valid;
    logic        busy;
    logic        err_pulse;

    card_selection_encoder #(.MAX_INDEX(MAXI), .DEBOUNCE_CYC(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_idx    (key_idx),
        .key_press  (key_press),
        .abort      (abort),
        .clear_done (clear_done),
        .data_out   (data_out),
        .sel_count  (sel_count),
        .sel_valid  (sel_valid),
        .busy       (busy),
        .err_pulse  (err_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int err_long = 0;
    logic err_prev = 1'b0;

    // Count error pulses and flag any that last more than one cycle.
    always begin
        @(posedge clk);
        #2;
        if (err_pulse === 1'b1) err_seen++;
        if (err_pulse === 1'b1 && err_prev === 1'b1) err_long++;
        err_prev = err_pulse;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [11:0] d, input logic [1:0] c,
                                 input logic v, input logic b, input int e, input int e_got);
        check({tag, ".data_out"},  32'(data_out),  32'(d));
        check({tag, ".sel_count"}, 32'(sel_count), 32'(c));
        check({tag, ".sel_valid"}, 32'(sel_valid), 32'(v));
        check({tag, ".busy"},      32'(busy),      32'(b));
        check({tag, ".err_count"}, 32'(e_got),     32'(e));
    endtask

    typedef enum int {A_PRESS, A_ABORT, A_CDH, A_CDL} act_t;

    task automatic do_action(input act_t a, input logic [3:0] idx, input int hold, input int extra);
        case (a)
            A_PRESS: begin
                @(negedge clk);
                key_idx   = idx;
                key_press = 1'b1;
                repeat (hold) @(negedge clk);
                key_press = 1'b0;
                repeat (D + 4) @(negedge clk);
            end
            A_ABORT: begin
                @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                repeat (2) @(negedge clk);
            end
            A_CDH: begin
                @(negedge clk);
                clear_done = 1'b1;
                repeat (2 + extra) @(negedge clk);
            end
            default: begin
                @(negedge clk);
                clear_done = 1'b0;
                repeat (2) @(negedge clk);
            end
        endcase
    endtask

    typedef struct {
        act_t        a;
        logic [3:0]  idx;
        int          extra;
        logic [11:0] d;
        logic [1:0]  c;
        logic        v;
        logic        b;
        int          e;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int          base;
        int          phase;   // 0 collecting, 1 requesting, 2 waiting for flag drop
        bit          cd_lvl;
        bit          bad;
        int          exp_err;
        int          r;
        int          hold;
        logic [3:0]  idx;
        logic [11:0] exp_data;
        logic [3:0]  picks[$];

        reset = 1'b1; key_idx = 4'd0; key_press = 1'b0; abort = 1'b0; clear_done = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("reset", 12'h000, 2'd0, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed vectors: complete round, rejects, busy-state picks, held handshake.
        vecs.push_back('{A_PRESS, 4'd5,  0, 12'h005, 2'd1, 1'b0, 1'b0, 0});
        vecs.push_back('{A_PRESS, 4'd3,  0, 12'h035, 2'd2, 1'b0, 1'b0, 0});
        vecs.push_back('{A_PRESS, 4'd7,  0, 12'h735, 2'd3, 1'b1, 1'b1, 0});
        vecs.push_back('{A_CDH,   4'd0,  0, 12'h735, 2'd3, 1'b0, 1'b1, 0});
        vecs.push_back('{A_CDL,   4'd0,  0, 12'h000, 2'd0, 1'b0, 1'b0, 0});
        vecs.push_back('{A_PRESS, 4'd0,  0, 12'h000, 2'd0, 1'b0, 1'b0, 1});
        vecs.push_back('{A_PRESS, 4'd10, 0, 12'h000, 2'd0, 1'b0, 1'b0, 1});
        vecs.push_back('{A_PRESS, 4'd5,  0, 12'h005, 2'd1, 1'b0, 1'b0, 0});
        vecs.push_back('{A_PRESS, 4'd5,  0, 12'h005, 2'd1, 1'b0, 1'b0, 1});
        vecs.push_back('{A_PRESS, 4'd1,  0, 12'h015, 2'd2, 1'b0, 1'b0, 0});
        vecs.push_back('{A_PRESS, 4'd2,  0, 12'h215, 2'd3, 1'b1, 1'b1, 0});
        vecs.push_back('{A_PRESS, 4'd3,  0, 12'h215, 2'd3, 1'b1, 1'b1, 1});
        vecs.push_back('{A_ABORT, 4'd0,  0, 12'h215, 2'd3, 1'b1, 1'b1, 0});
        vecs.push_back('{A_CDH,   4'd0, 50, 12'h215, 2'd3, 1'b0, 1'b1, 0});
        vecs.push_back('{A_PRESS, 4'd4,  0, 12'h215, 2'd3, 1'b0, 1'b1, 0});
        vecs.push_back('{A_CDL,   4'd0,  0, 12'h000, 2'd0, 1'b0, 1'b0, 0});
        vecs.push_back('{A_PRESS, 4'd9,  0, 12'h009, 2'd1, 1'b0, 1'b0, 0});
        vecs.push_back('{A_ABORT, 4'd0,  0, 12'h000, 2'd0, 1'b0, 1'b0, 0});

        foreach (vecs[i]) begin
            base = err_seen;
            do_action(vecs[i].a, vecs[i].idx, D + 2, vecs[i].extra);
            check_outputs($sformatf("vec%0d", i), vecs[i].d, vecs[i].c, vecs[i].v, vecs[i].b,
                          vecs[i].e, err_seen - base);
        end

        // Request appears one cycle after the third accept; reset mid-request clears everything.
        do_action(A_PRESS, 4'd5, D + 2, 0);
        do_action(A_PRESS, 4'd3, D + 2, 0);
        @(negedge clk);
        key_idx   = 4'd7;
        key_press = 1'b1;
        repeat (1 + D) @(posedge clk);
        #1;
        check("timing.valid_before", 32'(sel_valid), 32'd0);
        @(posedge clk);
        #1;
        check("timing.valid_after", 32'(sel_valid), 32'd1);
        check("timing.data_out",    32'(data_out),  32'h735);
        #2;
        reset = 1'b1;
        #1;
        check_outputs("async_reset", 12'h000, 2'd0, 1'b0, 1'b0, 0, 0);
        key_press = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Abort coinciding with the third accept discards everything without an error.
        do_action(A_PRESS, 4'd2, D + 2, 0);
        do_action(A_PRESS, 4'd8, D + 2, 0);
        check("abort.pre_data", 32'(data_out), 32'h082);
        base = err_seen;
        @(negedge clk);
        key_idx   = 4'd4;
        key_press = 1'b1;
        repeat (1 + D) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        key_press = 1'b0;
        repeat (D + 4) @(negedge clk);
        check_outputs("abort_accept", 12'h000, 2'd0, 1'b0, 1'b0, 0, err_seen - base);

        // Bouncing contact yields exactly one accept.
        base = err_seen;
        @(negedge clk);
        key_idx = 4'd6;
        for (int i = 0; i < 10; i++) begin
            key_press = (i % 2 == 0);
            @(negedge clk);
        end
        key_press = 1'b1;
        repeat (20) @(negedge clk);
        key_press = 1'b0;
        repeat (D + 4) @(negedge clk);
        check_outputs("bounce", 12'h006, 2'd1, 1'b0, 1'b0, 0, err_seen - base);

        // A press one cycle shorter than the debounce window is ignored.
        base = err_seen;
        @(negedge clk);
        key_idx   = 4'd9;
        key_press = 1'b1;
        repeat (D - 1) @(negedge clk);
        key_press = 1'b0;
        repeat (D + 4) @(negedge clk);
        check_outputs("short_press", 12'h006, 2'd1, 1'b0, 1'b0, 0, err_seen - base);

        // Randomized rounds against the pick-list model.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        phase  = 0;
        cd_lvl = 1'b0;
        picks.delete();
        for (int it = 0; it < 200; it++) begin
            r       = $urandom_range(0, 99);
            base    = err_seen;
            exp_err = 0;
            if (r < 60) begin
                if ($urandom_range(0, 9) < 7) idx = 4'($urandom_range(1, MAXI));
                else                          idx = 4'($urandom_range(0, 15));
                hold = $urandom_range(D, D + 6);
                do_action(A_PRESS, idx, hold, 0);
                if (phase == 0) begin
                    bad = (idx == 4'd0) || (int'(idx) > MAXI);
                    foreach (picks[k]) if (picks[k] == idx) bad = 1'b1;
                    if (bad) exp_err = 1;
                    else begin
                        picks.push_back(idx);
                        if (picks.size() == 3) phase = cd_lvl ? 2 : 1;
                    end
                end else if (phase == 1) begin
                    exp_err = 1;
                end
            end else if (r < 70) begin
                do_action(A_ABORT, 4'd0, 0, 0);
                if (phase == 0) picks.delete();
            end else if (r < 85) begin
                do_action(A_CDH, 4'd0, 0, $urandom_range(0, 5));
                cd_lvl = 1'b1;
                if (phase == 1) phase = 2;
            end else begin
                do_action(A_CDL, 4'd0, 0, 0);
                cd_lvl = 1'b0;
                if (phase == 2) begin
                    phase = 0;
                    picks.delete();
                end
            end
            exp_data = 12'h000;
            foreach (picks[k]) exp_data[4*k +: 4] = picks[k];
            check_outputs($sformatf("rand%0d", it), exp_data, 2'(picks.size()),
                          (phase == 1), (phase != 0), exp_err, err_seen - base);
        end

        check("err_pulse_width", 32'(err_long), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
